// File: rtl/warp_scheduler.sv
// warp_scheduler
//   Control-flow scheduler for one compute core that runs NUM_WARPS warps of a
//   single block. It sequences FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE for the
//   warp that currently owns the pipeline. Each warp keeps its own saved PC and
//   resume state. A RET hands the core to the next runnable warp in round-robin
//   order.
//
//   Optional feature: when the macro WARP_SWITCH_ON_STALL_EN is defined, a stall
//   in FETCH or WAIT also hands the core to the next runnable warp. When it is
//   undefined, a stalled warp waits in place.
//
// Ports
//   clk            in   core clock
//   reset_n        in   synchronous reset, active-low
//   start          in   dispatcher launch, held high until block_done is seen
//   warp_enable    in   warps present in the block, sampled in IDLE on start
//   decoded_ret    in   current instruction is RET
//   fetcher_state  in   active warp's fetcher state (3'b010 = FETCHED)
//   lsu_state      in   active warp's LSU states (2'b01 / 2'b10 = busy)
//   next_pc        in   per-thread next PC; the last lane is used
//   current_pc     out  PC of the active warp
//   core_state     out  pipeline state of the active warp
//   active_warp    out  warp owning the pipeline
//   warp_done      out  sticky per-warp RET-reached flags
//   block_done     out  all enabled warps done
module warp_scheduler #(
  parameter int NUM_WARPS         = 4,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = 8,
  localparam int WARP_W           = $clog2(NUM_WARPS)
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       start,
  input  logic [NUM_WARPS-1:0]                       warp_enable,
  input  logic                                       decoded_ret,
  input  logic [2:0]                                 fetcher_state,
  input  logic [THREADS_PER_BLOCK-1:0][1:0]          lsu_state,
  input  logic [THREADS_PER_BLOCK-1:0][PC_WIDTH-1:0] next_pc,
  output logic [PC_WIDTH-1:0]                        current_pc,
  output logic [2:0]                                 core_state,
  output logic [WARP_W-1:0]                          active_warp,
  output logic [NUM_WARPS-1:0]                       warp_done,
  output logic                                       block_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } corestate_t;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  corestate_t            r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [WARP_W-1:0]     r_warp;
  logic [NUM_WARPS-1:0]  r_done;
  logic                  r_block;
  logic [NUM_WARPS-1:0]  r_en;
  logic [PC_WIDTH-1:0]   r_saved_pc    [NUM_WARPS];
  corestate_t            r_saved_state [NUM_WARPS];

  corestate_t            w_state_nxt;
  logic [PC_WIDTH-1:0]   w_pc_nxt;
  logic [WARP_W-1:0]     w_warp_nxt;
  logic [NUM_WARPS-1:0]  w_done_nxt;
  logic                  w_block_nxt;
  logic [NUM_WARPS-1:0]  w_en_nxt;
  logic                  w_save_we;
  logic [PC_WIDTH-1:0]   w_save_pc;
  corestate_t            w_save_state;
  logic                  w_ctx_clr;

  logic                  w_fetched;
  logic                  w_lsu_busy;
  logic [NUM_WARPS-1:0]  w_runnable;
  logic                  w_pick_vld;
  logic [WARP_W-1:0]     w_pick;
  logic [WARP_W-1:0]     w_cand;
  logic [WARP_W-1:0]     w_first;
  logic                  w_unused_next_pc;

  // Only the last lane's next PC matters since branch divergence is unsupported.
  assign w_unused_next_pc = ^next_pc;

  assign w_fetched = (fetcher_state == FETCHER_FETCHED);

  always_comb begin
    w_lsu_busy = 1'b0;
    for (int t = 0; t < THREADS_PER_BLOCK; t++) begin
      if (lsu_state[t] == 2'b01 || lsu_state[t] == 2'b10) w_lsu_busy = 1'b1;
    end
  end

  // Round-robin pick: scan offsets from far to near so the nearest runnable
  // warp after the active one is the last assignment and wins.
  always_comb begin
    w_runnable         = r_en & ~r_done;
    w_runnable[r_warp] = 1'b0;
    w_pick_vld         = 1'b0;
    w_pick             = '0;
    w_cand             = '0;
    for (int k = NUM_WARPS - 1; k >= 1; k--) begin
      w_cand = WARP_W'((int'(r_warp) + k) % NUM_WARPS);
      if (w_runnable[w_cand]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_cand;
      end
    end
  end

  // Lowest enabled warp at launch (descending scan, lowest index wins).
  always_comb begin
    w_first = '0;
    for (int k = NUM_WARPS - 1; k >= 0; k--) begin
      if (warp_enable[k]) w_first = WARP_W'(k);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_warp_nxt   = r_warp;
    w_done_nxt   = r_done;
    w_block_nxt  = r_block;
    w_en_nxt     = r_en;
    w_save_we    = 1'b0;
    w_save_pc    = r_pc;
    w_save_state = S_FETCH;
    w_ctx_clr    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_en_nxt = warp_enable;
          if (warp_enable == '0) begin
            w_state_nxt = S_DONE;
            w_block_nxt = 1'b1;
          end else begin
            w_warp_nxt  = w_first;
            w_state_nxt = S_FETCH;
            w_pc_nxt    = '0;
          end
        end
      end
      S_FETCH: begin
        if (w_fetched) w_state_nxt = S_DECODE;
      end
      S_DECODE:  w_state_nxt = S_REQUEST;
      S_REQUEST: begin
        if (decoded_ret) begin
          w_done_nxt[r_warp] = 1'b1;
          if (w_pick_vld) begin
            w_warp_nxt  = w_pick;
            w_pc_nxt    = r_saved_pc[w_pick];
            w_state_nxt = r_saved_state[w_pick];
          end else begin
            w_state_nxt = S_DONE;
            w_block_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_lsu_busy) w_state_nxt = S_EXECUTE;
      end
      S_EXECUTE: w_state_nxt = S_UPDATE;
      S_UPDATE: begin
        w_pc_nxt     = next_pc[THREADS_PER_BLOCK-1];
        w_save_we    = 1'b1;
        w_save_pc    = next_pc[THREADS_PER_BLOCK-1];
        w_save_state = S_FETCH;
        w_state_nxt  = S_FETCH;
      end
      S_DONE: begin
        // Leaving DONE returns the whole block context to its launch values.
        if (!start) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = '0;
          w_block_nxt = 1'b0;
          w_en_nxt    = '0;
          w_pc_nxt    = '0;
          w_warp_nxt  = '0;
          w_ctx_clr   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

`ifdef WARP_SWITCH_ON_STALL_EN
    // Stall hand-off: park the stalled warp in its current state and bring in
    // the picked warp's context on the same edge. No pick: stay and retry.
    if (((r_state == S_FETCH) && !w_fetched) ||
        ((r_state == S_WAIT) && w_lsu_busy)) begin
      if (w_pick_vld) begin
        w_save_we    = 1'b1;
        w_save_pc    = r_pc;
        w_save_state = r_state;
        w_warp_nxt   = w_pick;
        w_pc_nxt     = r_saved_pc[w_pick];
        w_state_nxt  = r_saved_state[w_pick];
      end
    end
`endif
  end

  // State and context registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_warp  <= '0;
      r_done  <= '0;
      r_block <= 1'b0;
      r_en    <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_saved_pc[w]    <= '0;
        r_saved_state[w] <= S_FETCH;
      end
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_warp  <= w_warp_nxt;
      r_done  <= w_done_nxt;
      r_block <= w_block_nxt;
      r_en    <= w_en_nxt;
      if (w_ctx_clr) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
          r_saved_pc[w]    <= '0;
          r_saved_state[w] <= S_FETCH;
        end
      end else if (w_save_we) begin
        r_saved_pc[r_warp]    <= w_save_pc;
        r_saved_state[r_warp] <= w_save_state;
      end
    end
  end

  // Outputs
  always_comb begin
    current_pc  = r_pc;
    core_state  = r_state;
    active_warp = r_warp;
    warp_done   = r_done;
    block_done  = r_block;
  end

endmodule

// File: tb/tb_warp_scheduler.sv
module tb_warp_scheduler;
  localparam int NW  = 4;
  localparam int NT  = 4;
  localparam int PCW = 8;
`ifdef WARP_SWITCH_ON_STALL_EN
  localparam bit SWITCH = 1'b1;
`else
  localparam bit SWITCH = 1'b0;
`endif

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_REQUEST = 3;
  localparam int S_WAIT = 4, S_EXECUTE = 5, S_UPDATE = 6, S_DONE = 7;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    start;
  logic [NW-1:0]           warp_enable;
  logic                    decoded_ret;
  logic [2:0]              fetcher_state;
  logic [NT-1:0][1:0]      lsu_state;
  logic [NT-1:0][PCW-1:0]  next_pc;
  logic [PCW-1:0]          current_pc;
  logic [2:0]              core_state;
  logic [1:0]              active_warp;
  logic [NW-1:0]           warp_done;
  logic                    block_done;

  warp_scheduler #(.NUM_WARPS(NW), .THREADS_PER_BLOCK(NT), .PC_WIDTH(PCW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .warp_enable(warp_enable),
    .decoded_ret(decoded_ret), .fetcher_state(fetcher_state), .lsu_state(lsu_state),
    .next_pc(next_pc), .current_pc(current_pc), .core_state(core_state),
    .active_warp(active_warp), .warp_done(warp_done), .block_done(block_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: whole-block view with per-warp context arrays.
  int            m_state = S_IDLE, m_pc = 0, m_warp = 0;
  logic [NW-1:0] m_done = '0, m_en = '0;
  logic          m_block = 1'b0;
  int            m_spc [NW];
  int            m_sst [NW];

  // Stimulus configuration (per warp) for directed tests.
  bit cfg_fetch_ok [NW];
  bit cfg_busy     [NW];
  int cfg_ret_pc   [NW];
  bit rnd_mode = 1'b0;

  task automatic model_switch(input int p);
    m_spc[m_warp] = m_pc;
    m_sst[m_warp] = m_state;
    m_warp  = p;
    m_pc    = m_spc[p];
    m_state = m_sst[p];
  endtask

  task automatic model_clear_ctx();
    for (int w = 0; w < NW; w++) begin
      m_spc[w] = 0;
      m_sst[w] = S_FETCH;
    end
  endtask

  task automatic model_step();
    int  cand[$];
    bit  busy;
    if (!reset_n) begin
      m_state = S_IDLE; m_pc = 0; m_warp = 0; m_done = '0; m_block = 1'b0; m_en = '0;
      model_clear_ctx();
      return;
    end
    for (int k = 1; k < NW; k++) begin
      int w;
      w = (m_warp + k) % NW;
      if (m_en[w] && !m_done[w]) cand.push_back(w);
    end
    busy = 1'b0;
    for (int t = 0; t < NT; t++) if (lsu_state[t] == 2'b01 || lsu_state[t] == 2'b10) busy = 1'b1;
    case (m_state)
      S_IDLE: if (start) begin
        m_en = warp_enable;
        if (warp_enable == 4'b0) begin
          m_state = S_DONE; m_block = 1'b1;
        end else begin
          for (int w = NW - 1; w >= 0; w--) if (warp_enable[w]) m_warp = w;
          m_state = S_FETCH; m_pc = 0;
        end
      end
      S_FETCH: begin
        if (fetcher_state == 3'b010) m_state = S_DECODE;
        else if (SWITCH && cand.size() > 0) model_switch(cand[0]);
      end
      S_DECODE:  m_state = S_REQUEST;
      S_REQUEST: begin
        if (decoded_ret) begin
          m_done[m_warp] = 1'b1;
          if (cand.size() > 0) begin
            m_warp = cand[0]; m_pc = m_spc[cand[0]]; m_state = m_sst[cand[0]];
          end else begin
            m_state = S_DONE; m_block = 1'b1;
          end
        end else m_state = S_WAIT;
      end
      S_WAIT: begin
        if (!busy) m_state = S_EXECUTE;
        else if (SWITCH && cand.size() > 0) model_switch(cand[0]);
      end
      S_EXECUTE: m_state = S_UPDATE;
      S_UPDATE: begin
        m_pc = int'(next_pc[NT-1]);
        m_spc[m_warp] = m_pc;
        m_state = S_FETCH;
      end
      default: if (!start) begin
        m_state = S_IDLE; m_done = '0; m_block = 1'b0; m_en = '0; m_pc = 0; m_warp = 0;
        model_clear_ctx();
      end
    endcase
  endtask

  task automatic drive();
    if (rnd_mode) begin
      fetcher_state = ($urandom_range(0, 3) != 0) ? 3'b010 : 3'($urandom_range(0, 7));
      for (int t = 0; t < NT; t++) begin
        lsu_state[t] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        next_pc[t]   = 8'($urandom_range(0, 255));
      end
      decoded_ret = ($urandom_range(0, 3) == 0);
    end else begin
      fetcher_state = cfg_fetch_ok[m_warp] ? 3'b010 : 3'b000;
      lsu_state = '0;
      if (cfg_busy[m_warp]) lsu_state[0] = 2'b01;
      decoded_ret = (cfg_ret_pc[m_warp] == m_pc);
      for (int t = 0; t < NT; t++) next_pc[t] = 8'(m_pc + 1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    drive();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_cfg(input bit fetch_ok, input bit busy, input int ret_pc);
    for (int w = 0; w < NW; w++) begin
      cfg_fetch_ok[w] = fetch_ok; cfg_busy[w] = busy; cfg_ret_pc[w] = ret_pc;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; warp_enable = 4'hF;
    tick(); tick();
    n_cmp++; if (current_pc !== 8'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", current_pc); end
    n_cmp++; if (core_state !== 3'(S_IDLE)) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", core_state, S_IDLE); end
    n_cmp++; if (active_warp !== 2'd0) begin n_fail++; $display("FAIL reset_warp: got %0d expected 0", active_warp); end
    n_cmp++; if (warp_done !== 4'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0000", warp_done); end
    n_cmp++; if (block_done !== 1'b0) begin n_fail++; $display("FAIL reset_block: got %b expected 0", block_done); end
    reset_n = 1'b1;
    tick(); tick();
    n_cmp++; if (core_state !== 3'(S_IDLE)) begin n_fail++; $display("FAIL idle_no_start: got %0d expected %0d", core_state, S_IDLE); end
  endtask

  task automatic test_ret_round_robin();
    set_cfg(1'b1, 1'b0, 2);
    warp_enable = 4'b0011; start = 1'b1;
    tick();
    n_cmp++; if (core_state !== 3'(S_FETCH) || active_warp !== 2'd0 || current_pc !== 8'd0) begin
      n_fail++; $display("FAIL rr_launch: got st=%0d w=%0d pc=%0d expected st=1 w=0 pc=0", core_state, active_warp, current_pc); end
    repeat (6) tick();
    n_cmp++; if (core_state !== 3'(S_FETCH) || current_pc !== 8'd1) begin
      n_fail++; $display("FAIL rr_pc1: got st=%0d pc=%0d expected st=1 pc=1", core_state, current_pc); end
    repeat (9) tick();
    n_cmp++; if (active_warp !== 2'd1 || core_state !== 3'(S_FETCH) || current_pc !== 8'd0) begin
      n_fail++; $display("FAIL rr_switch: got w=%0d st=%0d pc=%0d expected w=1 st=1 pc=0", active_warp, core_state, current_pc); end
    n_cmp++; if (warp_done !== 4'b0001) begin n_fail++; $display("FAIL rr_done0: got %b expected 0001", warp_done); end
    repeat (15) tick();
    n_cmp++; if (core_state !== 3'(S_DONE) || block_done !== 1'b1) begin
      n_fail++; $display("FAIL rr_block: got st=%0d bd=%b expected st=7 bd=1", core_state, block_done); end
    n_cmp++; if (warp_done !== 4'b0011) begin n_fail++; $display("FAIL rr_done_all: got %b expected 0011", warp_done); end
    tick();
    n_cmp++; if (core_state !== 3'(S_DONE) || block_done !== 1'b1) begin
      n_fail++; $display("FAIL rr_hold: got st=%0d bd=%b expected st=7 bd=1", core_state, block_done); end
    start = 1'b0;
    tick();
    n_cmp++; if (core_state !== 3'(S_IDLE) || block_done !== 1'b0 || warp_done !== 4'b0 || current_pc !== 8'd0 || active_warp !== 2'd0) begin
      n_fail++; $display("FAIL rr_clear: got st=%0d bd=%b wd=%b pc=%0d w=%0d expected all idle/zero", core_state, block_done, warp_done, current_pc, active_warp); end
  endtask

  task automatic test_stall_switch();
    int e_warp, e_state, e_pc;
`ifdef WARP_SWITCH_ON_STALL_EN
    e_warp = 1; e_state = S_FETCH; e_pc = 0;
`else
    e_warp = 0; e_state = S_WAIT; e_pc = 1;
`endif
    set_cfg(1'b1, 1'b0, 2);
    warp_enable = 4'b0011; start = 1'b1;
    tick();
    for (int n = 0; n < 30 && !(m_state == S_WAIT && m_pc == 1); n++) tick();
    n_cmp++; if (core_state !== 3'(S_WAIT) || current_pc !== 8'd1) begin
      n_fail++; $display("FAIL ss_reach_wait: got st=%0d pc=%0d expected st=4 pc=1", core_state, current_pc); end
    cfg_busy[0] = 1'b1;
    tick();
    n_cmp++; if (active_warp !== 2'(e_warp) || core_state !== 3'(e_state) || current_pc !== 8'(e_pc)) begin
      n_fail++; $display("FAIL ss_first_stall: got w=%0d st=%0d pc=%0d expected w=%0d st=%0d pc=%0d", active_warp, core_state, current_pc, e_warp, e_state, e_pc); end
    cfg_fetch_ok[1] = 1'b0;
    tick();
    n_cmp++; if (active_warp !== 2'd0 || core_state !== 3'(S_WAIT) || current_pc !== 8'd1) begin
      n_fail++; $display("FAIL ss_resume: got w=%0d st=%0d pc=%0d expected w=0 st=4 pc=1", active_warp, core_state, current_pc); end
    repeat (3) begin
      tick();
      n_cmp++; if (active_warp !== 2'(m_warp) || core_state !== 3'(m_state) || current_pc !== 8'(m_pc)) begin
        n_fail++; $display("FAIL ss_busy: got w=%0d st=%0d pc=%0d expected w=%0d st=%0d pc=%0d", active_warp, core_state, current_pc, m_warp, m_state, m_pc); end
    end
    cfg_busy[0] = 1'b0; cfg_fetch_ok[1] = 1'b1;
    for (int n = 0; n < 200 && !m_block; n++) begin
      tick();
      n_cmp++; if (active_warp !== 2'(m_warp) || core_state !== 3'(m_state) || current_pc !== 8'(m_pc) || warp_done !== m_done) begin
        n_fail++; $display("FAIL ss_run: got w=%0d st=%0d pc=%0d wd=%b expected w=%0d st=%0d pc=%0d wd=%b", active_warp, core_state, current_pc, warp_done, m_warp, m_state, m_pc, m_done); end
`ifndef WARP_SWITCH_ON_STALL_EN
      if (!m_done[0]) begin
        n_cmp++; if (active_warp !== 2'd0) begin n_fail++; $display("FAIL ss_no_switch: got w=%0d expected 0 before RET", active_warp); end
      end
`endif
    end
    n_cmp++; if (block_done !== 1'b1 || warp_done !== 4'b0011) begin
      n_fail++; $display("FAIL ss_finish: got bd=%b wd=%b expected bd=1 wd=0011", block_done, warp_done); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_single_warp_stall();
    set_cfg(1'b1, 1'b0, 2);
    warp_enable = 4'b0001; start = 1'b1;
    tick();
    for (int n = 0; n < 10 && m_state != S_WAIT; n++) tick();
    cfg_busy[0] = 1'b1;
    repeat (4) begin
      tick();
      n_cmp++; if (core_state !== 3'(S_WAIT) || active_warp !== 2'd0) begin
        n_fail++; $display("FAIL sw_hold: got st=%0d w=%0d expected st=4 w=0", core_state, active_warp); end
    end
    cfg_busy[0] = 1'b0;
    tick();
    n_cmp++; if (core_state !== 3'(S_EXECUTE)) begin n_fail++; $display("FAIL sw_exec: got %0d expected %0d", core_state, S_EXECUTE); end
    for (int n = 0; n < 100 && !m_block; n++) tick();
    n_cmp++; if (block_done !== 1'b1 || warp_done !== 4'b0001) begin
      n_fail++; $display("FAIL sw_finish: got bd=%b wd=%b expected bd=1 wd=0001", block_done, warp_done); end
    start = 1'b0;
    tick();
    n_cmp++; if (core_state !== 3'(S_IDLE)) begin n_fail++; $display("FAIL sw_idle: got %0d expected 0", core_state); end
  endtask

  task automatic test_wrap_skip();
    int e5_warp, e6_warp, e7_warp;
    logic [3:0] e5_done;
`ifdef WARP_SWITCH_ON_STALL_EN
    e5_warp = 3; e6_warp = 0; e7_warp = 2; e5_done = 4'b0010;
`else
    e5_warp = 0; e6_warp = 0; e7_warp = 0; e5_done = 4'b0000;
`endif
    set_cfg(1'b0, 1'b0, -1);
    cfg_fetch_ok[1] = 1'b1; cfg_ret_pc[1] = 0;
    warp_enable = 4'hF; start = 1'b1;
    tick();
    repeat (5) tick();
    n_cmp++; if (active_warp !== 2'(e5_warp) || warp_done !== e5_done) begin
      n_fail++; $display("FAIL wr_at3: got w=%0d wd=%b expected w=%0d wd=%b", active_warp, warp_done, e5_warp, e5_done); end
    tick();
    n_cmp++; if (active_warp !== 2'(e6_warp) || core_state !== 3'(S_FETCH)) begin
      n_fail++; $display("FAIL wr_wrap: got w=%0d st=%0d expected w=%0d st=1", active_warp, core_state, e6_warp); end
    tick();
    n_cmp++; if (active_warp !== 2'(e7_warp)) begin n_fail++; $display("FAIL wr_skip_done: got %0d expected %0d", active_warp, e7_warp); end
    reset_n = 1'b0; start = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_op();
    set_cfg(1'b1, 1'b0, -1);
    warp_enable = 4'b0100; start = 1'b1;
    tick();
    for (int n = 0; n < 10 && m_state != S_EXECUTE; n++) tick();
    n_cmp++; if (core_state !== 3'(S_EXECUTE) || active_warp !== 2'd2) begin
      n_fail++; $display("FAIL rm_exec: got st=%0d w=%0d expected st=5 w=2", core_state, active_warp); end
    reset_n = 1'b0;
    tick();
    n_cmp++; if (core_state !== 3'(S_IDLE) || active_warp !== 2'd0 || current_pc !== 8'd0 || warp_done !== 4'b0 || block_done !== 1'b0) begin
      n_fail++; $display("FAIL rm_reset: got st=%0d w=%0d pc=%0d wd=%b bd=%b expected all reset", core_state, active_warp, current_pc, warp_done, block_done); end
    reset_n = 1'b1;
    tick();
    n_cmp++; if (core_state !== 3'(S_FETCH) || active_warp !== 2'd2 || current_pc !== 8'd0) begin
      n_fail++; $display("FAIL rm_relaunch: got st=%0d w=%0d pc=%0d expected st=1 w=2 pc=0", core_state, active_warp, current_pc); end
    reset_n = 1'b0; start = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    rnd_mode = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      reset_n = ($urandom_range(0, 149) != 0);
      if (m_state == S_IDLE) begin
        start = ($urandom_range(0, 2) != 0);
        warp_enable = 4'($urandom_range(0, 15));
      end else if (m_state == S_DONE) begin
        start = ($urandom_range(0, 1) != 0);
      end else begin
        start = 1'b1;
      end
      tick();
      n_cmp++; if (current_pc !== 8'(m_pc)) begin n_fail++; $display("FAIL rnd_pc cyc %0d: got %0d expected %0d", c, current_pc, m_pc); end
      n_cmp++; if (core_state !== 3'(m_state)) begin n_fail++; $display("FAIL rnd_state cyc %0d: got %0d expected %0d", c, core_state, m_state); end
      n_cmp++; if (active_warp !== 2'(m_warp)) begin n_fail++; $display("FAIL rnd_warp cyc %0d: got %0d expected %0d", c, active_warp, m_warp); end
      n_cmp++; if (warp_done !== m_done) begin n_fail++; $display("FAIL rnd_done cyc %0d: got %b expected %b", c, warp_done, m_done); end
      n_cmp++; if (block_done !== m_block) begin n_fail++; $display("FAIL rnd_block cyc %0d: got %b expected %b", c, block_done, m_block); end
    end
    rnd_mode = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; warp_enable = '0; decoded_ret = 1'b0;
    fetcher_state = '0; lsu_state = '0; next_pc = '0;
    model_clear_ctx();
    set_cfg(1'b1, 1'b0, -1);
    test_reset();
    test_ret_round_robin();
    test_stall_switch();
    test_single_warp_stall();
    test_wrap_skip();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
